// File: rtl/func_sweep_pkg.sv
// Shared types, sizes and the step-to-vector mapping for the function-cell sweep driver.
// Define FUNC_SWEEP_GRAY_EN to walk the vectors in Gray order instead of binary order.
package func_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VEC = 8;
  localparam int STEP_W  = 3;

  // Gray order flips exactly one cell input per step to limit glitching at the cell.
  function automatic logic [STEP_W-1:0] step_to_vec(input logic [STEP_W-1:0] step);
`ifdef FUNC_SWEEP_GRAY_EN
    return step ^ (step >> 2'd1);
`else
    return step;
`endif
  endfunction

endpackage

// File: rtl/func_vec_gen.sv
// Step counter and registered vector mapping that drives the a/b/c inputs of the cell.
module func_vec_gen
  import func_sweep_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              adv,
  output logic [STEP_W-1:0] vec,
  output logic              last
);

  logic [STEP_W-1:0] step_r;
  logic [STEP_W-1:0] vec_r;
  logic [STEP_W-1:0] step_nxt_s;

  assign step_nxt_s = step_r + 3'd1;

  // Step counter with the vector registered alongside so a/b/c come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_r <= 3'd0;
      vec_r  <= 3'd0;
    end else if (load) begin
      step_r <= 3'd0;
      vec_r  <= step_to_vec(3'd0);
    end else if (adv) begin
      step_r <= step_nxt_s;
      vec_r  <= step_to_vec(step_nxt_s);
    end
  end

  assign vec  = vec_r;
  assign last = (step_r == 3'(NUM_VEC - 1));

endmodule

// File: rtl/func_sweep_driver.sv
// Sweeps a 3-input function cell through all 8 input vectors and checks y against TRUTH_TABLE.
// Define FUNC_SWEEP_GRAY_EN to visit the vectors in Gray order (results stay indexed by vector value).
module func_sweep_driver
  import func_sweep_pkg::*;
#(
  parameter int          SETTLE_CYC  = 2,
  parameter logic [7:0]  TRUTH_TABLE = 8'hCC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] mismatch,
  output logic [3:0] fail_count
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t            state_r, state_nxt_s;
  logic [3:0]        cnt_r, cnt_nxt_s;
  logic [7:0]        mismatch_r, mismatch_nxt_s;
  logic [3:0]        fail_r, fail_nxt_s;
  logic              busy_r, done_r, pass_r;
  logic              load_s, adv_s;
  logic [STEP_W-1:0] vec_s;
  logic              last_s;

  func_vec_gen u_vec_gen (
    .clk  (clk),
    .rst  (rst),
    .load (load_s),
    .adv  (adv_s),
    .vec  (vec_s),
    .last (last_s)
  );

  // Next-state, settle counter and result accumulation.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    mismatch_nxt_s = mismatch_r;
    fail_nxt_s     = fail_r;
    load_s         = 1'b0;
    adv_s          = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_nxt_s    = SETTLE;
          cnt_nxt_s      = 4'd0;
          mismatch_nxt_s = 8'h00;
          fail_nxt_s     = 4'd0;
          load_s         = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      SETTLE: begin
        cnt_nxt_s = cnt_r + 4'd1;
        if (cnt_r == SETTLE_LAST) begin
          state_nxt_s = SAMPLE;
        end else begin
          state_nxt_s = SETTLE;
        end
      end
      SAMPLE: begin
        // y_in is sampled raw; the settle window is what makes it safe.
        if (y_in != TRUTH_TABLE[vec_s]) begin
          mismatch_nxt_s[vec_s] = 1'b1;
          fail_nxt_s            = fail_r + 4'd1;
        end else begin
          fail_nxt_s = fail_r;
        end
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SETTLE;
          adv_s       = 1'b1;
          cnt_nxt_s   = 4'd0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and result registers; status flags are derived from next state so they stay registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      mismatch_r <= 8'h00;
      fail_r     <= 4'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      mismatch_r <= mismatch_nxt_s;
      fail_r     <= fail_nxt_s;
      busy_r     <= (state_nxt_s == SETTLE) || (state_nxt_s == SAMPLE);
      done_r     <= (state_nxt_s == DONE);
      pass_r     <= (state_nxt_s == DONE) && (mismatch_nxt_s == 8'h00);
    end
  end

  assign a          = vec_s[2];
  assign b          = vec_s[1];
  assign c          = vec_s[0];
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign mismatch   = mismatch_r;
  assign fail_count = fail_r;

endmodule
